// File: rtl/res_serie_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding, default width and counter sizing.
package res_serie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int N_DEF = 8;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/res_serie_res1b.sv
// One-bit full subtractor cell.
// Purely combinational.
module res1b (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic dif,
  output logic bo
);

  assign dif = a ^ b ^ bi;
  assign bo  = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/res_serie.sv
// Bit-serial N-bit subtractor, LSB first.
// dif/bo update only on entry to FIN.
module res_serie
  import res_serie_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dif,
  output logic         bo
);

  localparam int CW = cnt_w(N);

  state_t        state;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [N-1:0]  rd;
  logic          br;
  logic [CW-1:0] cnt;
  logic          d;
  logic          bn;
  logic [N:0]    rd_sh;

  res1b u_cell (
    .a  (ra[0]),
    .b  (rb[0]),
    .bi (br),
    .dif(d),
    .bo (bn)
  );

  // Wide concat keeps the shift legal for N=1
  assign rd_sh = {d, rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dif   <= '0;
      bo    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= bi;
            rd    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          br <= bn;
          rd <= rd_sh[N:1];
          if (cnt == CW'(N - 1)) begin
            dif   <= rd_sh[N:1];
            bo    <= bn;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_serie.sv
// Bench for res_serie (N=8 and N=1) and res1b.
// Random operands checked against plain integer subtraction.
module tb_res_serie;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bi;
  logic       sel;

  logic       st8, st1;
  logic       busy8, done8, bo8;
  logic [7:0] dif8;
  logic       busy1, done1, bo1;
  logic [0:0] dif1;

  logic       busy_s, done_s, bo_s;
  logic [7:0] dif_s;

  logic       t_a, t_b, t_bi, t_dif, t_bo;

  int checks = 0;
  int errors = 0;
  logic [7:0] pdif [2];
  logic       pbo  [2];

  always #5 clk = ~clk;

  assign st8    = start & ~sel;
  assign st1    = start & sel;
  assign busy_s = sel ? busy1 : busy8;
  assign done_s = sel ? done1 : done8;
  assign bo_s   = sel ? bo1 : bo8;
  assign dif_s  = sel ? {7'b0, dif1} : dif8;

  res_serie #(.N(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(st8),
    .a    (a),
    .b    (b),
    .bi   (bi),
    .busy (busy8),
    .done (done8),
    .dif  (dif8),
    .bo   (bo8)
  );

  res_serie #(.N(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(st1),
    .a    (a[0:0]),
    .b    (b[0:0]),
    .bi   (bi),
    .busy (busy1),
    .done (done1),
    .dif  (dif1),
    .bo   (bo1)
  );

  res1b u_cell (
    .a  (t_a),
    .b  (t_b),
    .bi (t_bi),
    .dif(t_dif),
    .bo (t_bo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after FIN.
  task automatic run_op(input int n, input logic [7:0] av,
                        input logic [7:0] bv, input logic biv);
    int lat;
    int diff;
    int mask;
    int k;
    mask = (n == 1) ? 1 : 255;
    k = (n == 1) ? 1 : 0;
    sel = (n == 1);
    a = av;
    b = bv;
    bi = biv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bi = 1'($urandom);
    lat = 1;
    while (!done_s && lat < 40) begin
      chk("busy", 32'(busy_s), 32'd1);
      chk("hold_dif", 32'(dif_s), 32'(pdif[k]));
      chk("hold_bo", 32'(bo_s), 32'(pbo[k]));
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n + 1);
    diff = (int'(av) & mask) - (int'(bv) & mask) - int'(biv);
    chk("dif", 32'(dif_s), 32'(diff & mask));
    chk("bo", 32'(bo_s), 32'(diff < 0));
    chk("fin_busy", 32'(busy_s), 32'd0);
    pdif[k] = 8'(diff & mask);
    pbo[k] = (diff < 0);
    @(negedge clk);
    chk("gap_done", 32'(done_s), 32'd0);
    chk("gap_busy", 32'(busy_s), 32'd0);
  endtask

  initial begin
    int nd;
    int s;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bi = 1'b0;
    sel = 1'b0;
    pdif[0] = '0;
    pdif[1] = '0;
    pbo[0] = 1'b0;
    pbo[1] = 1'b0;

    for (int i = 0; i < 8; i++) begin
      t_a = i[2];
      t_b = i[1];
      t_bi = i[0];
      #1;
      s = int'(t_a) - int'(t_b) - int'(t_bi);
      chk("cell_dif", 32'(t_dif), 32'(s & 1));
      chk("cell_bo", 32'(t_bo), 32'(s < 0));
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_dif", 32'(dif8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 8'd100, 8'd37, 1'b0);
    run_op(8, 8'd37, 8'd100, 1'b0);
    run_op(8, 8'd0, 8'd0, 1'b1);

    // Extra starts during RUN and FIN must be dropped
    sel = 1'b0;
    a = 8'hAA;
    b = 8'h55;
    bi = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    if (done8) nd++;
    a = 8'h03;
    b = 8'h07;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) nd++;
      @(negedge clk);
    end
    chk("one_done", nd, 1);
    chk("ign_dif", 32'(dif8), 32'h55);
    chk("ign_bo", 32'(bo8), 32'd0);
    pdif[0] = 8'h55;
    pbo[0] = 1'b0;

    run_op(8, 8'd100, 8'd37, 1'b0);
    run_op(8, 8'h10, 8'h01, 1'b0);

    // Asynchronous abort in RUN cycle 4
    sel = 1'b0;
    a = 8'h5A;
    b = 8'h13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_dif", 32'(dif8), 32'd0);
    chk("abort_bo", 32'(bo8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) nd++;
      @(negedge clk);
    end
    chk("abort_nodone", nd, 0);
    pdif[0] = '0;
    pbo[0] = 1'b0;
    pdif[1] = '0;
    pbo[1] = 1'b0;
    run_op(8, 8'hFF, 8'hFF, 1'b1);

    repeat (2000) run_op(8, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3000) run_op(1, 8'($urandom), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
